// File: rtl/seg7_pkg.sv
// Shared constants for the two-digit 7-segment scanner: active-low segment
// patterns, anode select codes and the slot phase encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;

  typedef enum logic {
    PH_UNITS = 1'b0,
    PH_TENS  = 1'b1
  } phase_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder ({g,f,e,d,c,b,a}).
// Codes 10..15 show a dash so a bad counter value is visible on the board.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_2digit.sv
// Two-digit multiplexed common-anode display driver with per-frame snapshot,
// guard cycles and dash for invalid codes. Define LEADING_ZERO_BLANK_EN to blank a zero tens digit.
module seg7_scan_2digit
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] dig1,
  input  logic [3:0] dig0,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt, cnt_next;
  phase_t        phase, phase_next;
  logic [3:0]    snap1, snap0;
  logic          tick, snap_load, in_guard, blank;
  logic [3:0]    sel_digit;
  logic [6:0]    dec_seg, seg_next;
  logic [1:0]    an_next;
  logic          fd_next;

  if (GUARD == 0) begin : g_no_guard
    assign in_guard = 1'b0;
  end else begin : g_guard
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
    assign in_guard = (cnt < GUARD_C);
  end

  // A zero tens digit turns the tens slot into a dark slot without changing timing
`ifdef LEADING_ZERO_BLANK_EN
  assign blank = (phase == PH_TENS) && (snap1 == 4'd0);
`else
  assign blank = 1'b0;
`endif

  assign tick      = (cnt == LAST);
  assign sel_digit = (phase == PH_TENS) ? snap1 : snap0;

  bcd_to_seg7 u_dec (
    .bcd (sel_digit),
    .seg (dec_seg)
  );

  always_comb begin
    cnt_next   = cnt;
    phase_next = phase;
    snap_load  = 1'b0;
    fd_next    = 1'b0;
    an_next    = AN_OFF;
    seg_next   = SEG_OFF;
    if (!enable) begin
      cnt_next   = '0;
      phase_next = PH_UNITS;
    end else begin
      cnt_next = tick ? '0 : cnt + 1'b1;
      if (tick) begin
        phase_next = (phase == PH_UNITS) ? PH_TENS : PH_UNITS;
      end
      snap_load = tick && (phase == PH_TENS);
      fd_next   = snap_load;
      if (!in_guard && !blank) begin
        an_next  = (phase == PH_TENS) ? AN_TENS : AN_UNITS;
        seg_next = dec_seg;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      phase      <= PH_UNITS;
      snap1      <= 4'd0;
      snap0      <= 4'd0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      phase      <= phase_next;
      an         <= an_next;
      seg        <= seg_next;
      frame_done <= fd_next;
      if (snap_load) begin
        snap1 <= dig1;
        snap0 <= dig0;
      end
    end
  end

  // Driving both anodes at once would short two digits onto one segment bus
  a_one_anode : assert property (@(posedge clock) disable iff (reset) an != 2'b00);

endmodule

// File: tb/tb_seg7_scan_2digit.sv
// Self-checking bench for seg7_scan_2digit: directed scenarios plus random
// digits/enable gaps, compared against a slot-position reference model.
module tb_seg7_scan_2digit;

  localparam int SD = 4;
  localparam int GD = 1;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] dig1, dig0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_done;

  int checkCount = 0;
  int errorCount = 0;

  // Reference state: position within the 2*SD-cycle frame and the shown digits
  int         pos;
  logic [3:0] refSnap1, refSnap0;
  logic [6:0] segTable [16];

  seg7_scan_2digit #(.SCAN_DIV(SD), .GUARD(GD)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .dig1       (dig1),
    .dig0       (dig0),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelOutputs(output logic [1:0] ean, output logic [6:0] eseg);
    int   offset;
    bit   tens;
    offset = pos % SD;
    tens   = (pos >= SD);
    ean    = 2'b11;
    eseg   = 7'h7F;
    if (offset >= GD && !(tens && BLANK && refSnap1 == 4'd0)) begin
      ean  = tens ? 2'b01 : 2'b10;
      eseg = tens ? segTable[refSnap1] : segTable[refSnap0];
    end
  endtask

  task automatic stepCycle();
    logic [1:0] ean;
    logic [6:0] eseg;
    logic       efd;
    if (enable) begin
      modelOutputs(ean, eseg);
      efd = (pos == 2 * SD - 1);
    end else begin
      ean  = 2'b11;
      eseg = 7'h7F;
      efd  = 1'b0;
    end
    @(posedge clock);
    #1;
    checkOutput("an", 32'(an), 32'(ean));
    checkOutput("seg", 32'(seg), 32'(eseg));
    checkOutput("frame_done", 32'(frame_done), 32'(efd));
    if (enable) begin
      if (pos == 2 * SD - 1) begin
        refSnap1 = dig1;
        refSnap0 = dig0;
      end
      pos = (pos + 1) % (2 * SD);
    end else begin
      pos = 0;
    end
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] d1, input logic [3:0] d0, input int n);
    enable = en;
    dig1   = d1;
    dig0   = d0;
    repeat (n) stepCycle();
  endtask

  task automatic runUntilPos(input int target);
    for (int i = 0; i < 4 * SD && pos != target; i++) stepCycle();
  endtask

  task automatic asyncReset();
    #2 reset = 1'b1;
    #1;
    checkOutput("async_an", 32'(an), 32'h3);
    checkOutput("async_seg", 32'(seg), 32'h7F);
    checkOutput("async_fd", 32'(frame_done), 32'h0);
    pos      = 0;
    refSnap1 = 4'd0;
    refSnap0 = 4'd0;
    @(posedge clock);
    #1;
    checkOutput("rst_hold_an", 32'(an), 32'h3);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    segTable = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    pos      = 0;
    refSnap1 = 4'd0;
    refSnap0 = 4'd0;
    reset    = 1'b1;
    enable   = 1'b1;
    dig1     = 4'd0;
    dig0     = 4'd0;

    repeat (5) begin
      @(posedge clock);
      #1;
      checkOutput("reset_an", 32'(an), 32'h3);
      checkOutput("reset_seg", 32'(seg), 32'h7F);
      checkOutput("reset_fd", 32'(frame_done), 32'h0);
    end
    @(negedge clock);
    reset = 1'b0;

    // Steady scan of 42, then change units mid tens slot
    applyStimulus(1'b1, 4'd4, 4'd2, 8 + 3 * 2 * SD);
    runUntilPos(SD + 1);
    applyStimulus(1'b1, 4'd4, 4'd7, 3 * SD);

    applyStimulus(1'b1, 4'd9, 4'hB, 4 * SD);

    // Enable gap in the middle of the tens slot
    runUntilPos(SD + 2);
    applyStimulus(1'b0, 4'd9, 4'hB, 3);
    applyStimulus(1'b1, 4'd9, 4'hB, 3 * SD);

    applyStimulus(1'b1, 4'd0, 4'd5, 5 * SD);

    runUntilPos(SD + 1);
    asyncReset();
    applyStimulus(1'b1, 4'd3, 4'd8, 6 * SD);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        dig1 = 4'($urandom_range(0, 15));
        dig0 = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 5) == 0) dig1 = 4'd0;
      enable = ($urandom_range(0, 15) != 0);
      stepCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
